// File: rtl/syscall_puts_unit.sv
// Print-string syscall engine: walks a NUL-terminated string in data memory one word at a time
// and streams its bytes on a ready/valid port. Optional simulator trace via SYSCALL_PUTS_TRACE_EN.
module syscall_puts_unit #(
    parameter int unsigned MAX_LEN    = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        printsig,
    input  logic [31:0] str,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        siggot,
    output logic        busy,
    output logic        truncated,
    output logic [2:0]  dbg_state_o
);

    localparam int unsigned   CW    = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q;
    logic           printsig_q;
    logic [31:0]    ptr_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    buf_q;
    logic           mem_rd_q;
    logic [31:0]    mem_addr_q;
    logic           char_valid_q;
    logic [7:0]     char_data_q;
    logic           siggot_q;
    logic           truncated_q;

    logic           start_d;
    logic [31:0]    ptr_inc_d;
    logic [CW-1:0]  count_inc_d;
    logic [7:0]     wait_byte_d;
    logic [7:0]     next_byte_d;

    // Byte at lane offset off; big-endian puts offset 0 in the top byte.
    function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] off);
        logic [1:0] idx;
        idx = BIG_ENDIAN ? ~off : off;
        case (idx)
            2'd0:    lane_sel = w[7:0];
            2'd1:    lane_sel = w[15:8];
            2'd2:    lane_sel = w[23:16];
            default: lane_sel = w[31:24];
        endcase
    endfunction

    assign start_d     = printsig & ~printsig_q & (state_q == S_IDLE);
    assign ptr_inc_d   = ptr_q + 32'd1;
    assign count_inc_d = count_q + CW'(1);
    assign wait_byte_d = lane_sel(mem_rdata, ptr_q[1:0]);
    assign next_byte_d = lane_sel(buf_q, ptr_inc_d[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            printsig_q   <= 1'b0;
            ptr_q        <= 32'd0;
            count_q      <= '0;
            buf_q        <= 32'd0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            char_valid_q <= 1'b0;
            char_data_q  <= 8'd0;
            siggot_q     <= 1'b0;
            truncated_q  <= 1'b0;
        end else begin
            printsig_q <= printsig;
            mem_rd_q   <= 1'b0;
            siggot_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        ptr_q       <= str;
                        count_q     <= '0;
                        truncated_q <= 1'b0;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= {str[31:2], 2'b00};
                        state_q     <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // The first lane is decoded straight off the read data so EMIT can present it at once.
                    buf_q        <= mem_rdata;
                    char_valid_q <= (wait_byte_d != 8'h00);
                    if (wait_byte_d != 8'h00) begin
                        char_data_q <= wait_byte_d;
                    end
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    if (!char_valid_q) begin
                        siggot_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (char_ready) begin
                        ptr_q   <= ptr_inc_d;
                        count_q <= count_inc_d;
                        if (count_inc_d == MAX_C) begin
                            truncated_q  <= 1'b1;
                            char_valid_q <= 1'b0;
                            siggot_q     <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (ptr_inc_d[1:0] == 2'b00) begin
                            char_valid_q <= 1'b0;
                            mem_rd_q     <= 1'b1;
                            mem_addr_q   <= {ptr_inc_d[31:2], 2'b00};
                            state_q      <= S_RD;
                        end else begin
                            char_valid_q <= (next_byte_d != 8'h00);
                            if (next_byte_d != 8'h00) begin
                                char_data_q <= next_byte_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign char_valid  = char_valid_q;
    assign char_data   = char_data_q;
    assign siggot      = siggot_q;
    assign busy        = (state_q != S_IDLE);
    assign truncated   = truncated_q;
    assign dbg_state_o = state_q;

`ifdef SYSCALL_PUTS_TRACE_EN
    always @(posedge clk) begin
        if (!reset && char_valid_q && char_ready) begin
            $write("%c", char_data_q);
        end
        if (!reset && state_q == S_DONE) begin
            $display("[puts] %0d chars%s", count_q, truncated_q ? " (truncated)" : "");
        end
    end
`else
`endif

endmodule

// File: tb/tb_syscall_puts_unit.sv
// Directed, table-driven bench for syscall_puts_unit with a word memory model and a
// character scoreboard; MAX_LEN is reduced to 4 so truncation is reachable.
module tb_syscall_puts_unit;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        printsig;
    logic [31:0] str;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        siggot;
    logic        busy;
    logic        truncated;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] mem [0:511];

    typedef struct {
        logic [31:0] str;
        logic [31:0] chars;
        int          n_chars;
        int          done;
        logic        trunc;
        int          stall;
        int          rds;
        logic [31:0] addr;
        logic        hold;
    } vec_t;

    vec_t vecs [7];

    syscall_puts_unit #(.MAX_LEN(MAXL), .BIG_ENDIAN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .printsig   (printsig),
        .str        (str),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .siggot     (siggot),
        .busy       (busy),
        .truncated  (truncated),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Read data appears one cycle after the strobe; junk otherwise.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[10:2]];
        else        mem_rdata <= 32'hDEAD_BEEF;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          c;
        int          done_c;
        int          n_sig;
        int          n_rd;
        int          n_ch;
        int          hb;
        logic [31:0] first_addr;
        logic [7:0]  e;
        exp_q.delete();
        for (int i = 0; i < v.n_chars; i++) exp_q.push_back(v.chars[31-8*i -: 8]);
        done_c = -1; n_sig = 0; n_rd = 0; n_ch = 0; first_addr = '1;
        str = v.str;
        @(posedge clk); #1;
        c = 0;
        printsig = 1'b1;
        char_ready = 1'b1;
        while (c < 40 && !(done_c >= 0 && c > done_c + 1)) begin
            @(negedge clk);
            if (mem_rd) begin
                if (n_rd == 0) first_addr = mem_addr;
                n_rd++;
            end
            if (siggot) begin
                n_sig++;
                if (done_c < 0) done_c = c;
            end
            if (c >= 3 && c < 3 + v.stall) begin
                check($sformatf("vec%0d stall_valid c%0d", idx, c), char_valid, 1);
                check($sformatf("vec%0d stall_data c%0d", idx, c), char_data, v.chars[31:24]);
            end
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vec%0d extra_char: got 0x%0h expected none", idx, char_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("vec%0d char%0d", idx, n_ch), char_data, e);
                end
                n_ch++;
            end
            @(posedge clk); #1;
            c++;
            char_ready = !(c >= 3 && c < 3 + v.stall);
        end
        check($sformatf("vec%0d done_cycle", idx), done_c, v.done);
        check($sformatf("vec%0d siggot_count", idx), n_sig, 1);
        check($sformatf("vec%0d char_count", idx), n_ch, v.n_chars);
        check($sformatf("vec%0d rd_count", idx), n_rd, v.rds);
        check($sformatf("vec%0d first_addr", idx), first_addr, v.addr);
        check($sformatf("vec%0d truncated", idx), truncated, v.trunc);
        check($sformatf("vec%0d busy_after", idx), busy, 0);
        if (v.hold) begin
            hb = 0;
            repeat (6) begin
                @(negedge clk);
                if (busy || mem_rd) hb++;
            end
            check($sformatf("vec%0d held_no_restart", idx), hb, 0);
        end
        printsig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n_sig;

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h4869_0000;
        mem[32'h200 >> 2] = 32'h0041_4243;
        mem[32'h300 >> 2] = 32'h0000_0041;
        mem[32'h304 >> 2] = 32'h4200_0000;
        mem[32'h400 >> 2] = 32'h4141_4141;
        mem[32'h404 >> 2] = 32'h4141_4141;
        mem[32'h500 >> 2] = 32'h4142_4300;
        mem[32'h600 >> 2] = 32'h0000_5A00;

        //             str         chars         n  done trunc stall rds addr        hold
        vecs[0] = '{32'h100, 32'h4869_0000, 2, 6, 1'b0, 0, 1, 32'h100, 1'b0};
        vecs[1] = '{32'h303, 32'h4142_0000, 2, 8, 1'b0, 0, 2, 32'h300, 1'b0};
        vecs[2] = '{32'h200, 32'h0000_0000, 0, 4, 1'b0, 0, 1, 32'h200, 1'b0};
        vecs[3] = '{32'h100, 32'h4869_0000, 2, 9, 1'b0, 3, 1, 32'h100, 1'b0};
        vecs[4] = '{32'h400, 32'h4141_4141, 4, 7, 1'b1, 0, 1, 32'h400, 1'b1};
        vecs[5] = '{32'h500, 32'h4142_4300, 3, 7, 1'b0, 0, 1, 32'h500, 1'b0};
        vecs[6] = '{32'h602, 32'h5A00_0000, 1, 5, 1'b0, 0, 1, 32'h600, 1'b0};

        reset = 1'b1; printsig = 1'b0; str = 32'd0; char_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mem_rd", mem_rd, 0);
        check("reset_char_valid", char_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_siggot", siggot, 0);
        check("post_reset_state", dbg_state, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while stalled in EMIT.
        str = 32'h100;
        @(posedge clk); #1;
        printsig = 1'b1; char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_pre_valid", char_valid, 1);
        @(posedge clk); #1;
        reset = 1'b1; printsig = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_char_valid", char_valid, 0);
        check("midrst_char_data", char_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_truncated", truncated, 0);
        n_sig = 0;
        repeat (6) begin
            @(negedge clk);
            if (siggot || busy) n_sig++;
        end
        check("midrst_quiet", n_sig, 0);
        @(posedge clk); #1;
        char_ready = 1'b1;
        run_vec(7, vecs[0]);

        // printsig held high through reset release starts a transfer immediately.
        str = 32'h100;
        reset = 1'b1; printsig = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_edge_mem_rd", mem_rd, 1);
        check("rst_edge_addr", mem_addr, 32'h100);
        n_sig = 0;
        repeat (10) begin
            @(negedge clk);
            if (siggot) n_sig++;
        end
        check("rst_edge_siggot", n_sig, 1);
        printsig = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_puts_unit.md
Name: syscall_puts_unit

Overview:
Services the print-string syscall (v0 == 4) raised by the instruction decoder. On a rising edge of printsig it walks the NUL-terminated string at address str (the $a0 value) in data memory, one word read at a time. It emits each byte on a ready/valid character stream and pulses siggot back to the decoder when the string is done. It sits beside the data memory, downstream of the decoder's printsig/str outputs, and shares a read port on the memory.

Parameters:
MAX_LEN, 1024, maximum characters emitted before forced termination (must be >= 1)
BIG_ENDIAN, 1, 1: byte offset 0 is bits [31:24]; 0: byte offset 0 is bits [7:0]

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
printsig  input  1  print request level from decoder; start on 0->1 transition
str  input  32  byte address of string, sampled on start
mem_rd  output  1  word read strobe to data memory
mem_addr  output  32  word-aligned read address ({ptr[31:2],2'b00})
mem_rdata  input  32  read data, valid exactly one cycle after mem_rd
char_valid  output  1  character available on char_data
char_data  output  8  current character (never 8'h00)
char_ready  input  1  console accepts character when high with char_valid
siggot  output  1  one-cycle completion pulse to decoder
busy  output  1  high in every state except IDLE
truncated  output  1  sticky: last string hit MAX_LEN without NUL; cleared on next start

Behaviour:
- Reset: state IDLE; mem_rd, char_valid, siggot, busy, truncated = 0; mem_addr = 0; char_data = 0; ptr, count, word buffer = 0; printsig_q = 0.
- Edge detect: printsig_q registers printsig every cycle. Start = printsig & ~printsig_q & (state == IDLE). A level held high never restarts. A rising edge while busy is ignored.
- Consequence of reset: printsig held high through reset deassert is seen as an edge and starts a transfer on the first cycle after reset.
- IDLE: on start, ptr <= str, count <= 0, truncated <= 0 -> RD.
- RD (1 cycle): mem_rd = 1, mem_addr = {ptr[31:2],2'b00} -> WAIT.
- WAIT (1 cycle): mem_rd = 0; word buffer <= mem_rdata -> EMIT.
- EMIT: byte = lane ptr[1:0] of the word buffer, lane order per BIG_ENDIAN.
  - byte == 0: -> DONE, char_valid = 0.
  - else: char_valid = 1, char_data = byte.
  - On char_valid & char_ready: ptr <= ptr + 1, count <= count + 1.
    - If count + 1 == MAX_LEN: truncated <= 1, -> DONE.
    - Else if (ptr + 1)[1:0] == 0: -> RD (next word).
    - Else stay in EMIT.
  - char_valid/char_data hold stable while char_ready is low.
- Unaligned str: first byte is lane str[1:0]. The same word is not re-read for later lanes.
- ptr wraps modulo 2^32. No fault is raised on wrap.
- DONE (1 cycle): siggot = 1 -> IDLE. siggot is high for exactly one cycle per accepted start.
- Latency, aligned 4-char string "abc\0" with char_ready tied high:
  - start seen in cycle 0; RD in cycle 1; WAIT in cycle 2.
  - chars in cycles 3, 4, 5; NUL detected in cycle 6 (EMIT, no valid).
  - DONE in cycle 7, i.e. siggot in cycle 7.
- Empty string (first byte NUL): no char_valid; siggot 4 cycles after start.
- Reset mid-operation: immediately returns to IDLE with reset values. No siggot is issued for the aborted string.

Optional Feature:
Macro SYSCALL_PUTS_TRACE_EN.
- Defined: every accepted character (char_valid & char_ready) is also printed with $write("%c", char_data). The DONE cycle additionally prints $display("[puts] %0d chars%s", count, truncated ? " (truncated)" : "").
- Undefined: no simulator output. The port-level behaviour is identical in both builds.

Test Plan:
- str=0x100, memory 0x100 = 0x48690000 ("Hi\0"), BIG_ENDIAN=1, char_ready=1, printsig 0->1 -> chars 0x48, 0x69 in cycles 3, 4; siggot exactly in cycle 6; one mem_rd, at 0x100.
- str=0x103, memory 0x100 = 0x00000041, 0x104 = 0x42000000 -> mem_rd at 0x100 then 0x104; chars 0x41, 0x42; one siggot; busy low afterwards.
- Empty string at 0x200 (word 0x00xxxxxx) -> no char_valid; siggot in cycle 4; truncated = 0.
- Backpressure: "Hi\0" with char_ready low for 3 cycles on the first char -> char_data stays 0x48 with valid held; sequence still 0x48, 0x69; siggot delayed by 3 cycles.
- MAX_LEN=4, memory filled with 0x41414141 -> exactly 4 chars; truncated = 1; single siggot; printsig held high afterwards -> no restart until it drops and rises again.
- Reset asserted for 1 cycle in the middle of EMIT -> next cycle all outputs at reset values; no siggot; a new printsig edge then completes normally.
